// File: rtl/regs_bank.sv
// Decode-stage register file: N combinational read ports with optional write-through,
// one synchronous write port, a debug watch port and a PC trace shift buffer.
`timescale 1ns/1ps

module regs_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int REG_COUNT   = 32,
  parameter int NUM_WIDTH   = $clog2(REG_COUNT),
  parameter int READ_PORTS  = 2,
  parameter int BYPASS      = 1,
  parameter int TRACE_DEPTH = 5,
  parameter int TIDX_WIDTH  = $clog2(TRACE_DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [READ_PORTS*NUM_WIDTH-1:0]  regNum,
  output logic [READ_PORTS*DATA_WIDTH-1:0] regReadData,
  input  logic                             regWriteEnable,
  input  logic [NUM_WIDTH-1:0]             regWriteNum,
  input  logic [DATA_WIDTH-1:0]            regWriteData,
  input  logic [NUM_WIDTH-1:0]             regWatchNum,
  output logic [DATA_WIDTH-1:0]            regWatchData,
  input  logic [ADDR_WIDTH-1:0]            PC,
  input  logic                             pcValid,
  input  logic [TIDX_WIDTH-1:0]            traceIndex,
  output logic [ADDR_WIDTH-1:0]            traceData,
  output logic [TIDX_WIDTH:0]              traceCount
);

  localparam bit                  BYPASS_ON  = (BYPASS != 0);
  localparam logic [TIDX_WIDTH:0] TRACE_FULL = (TIDX_WIDTH + 1)'(TRACE_DEPTH);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [ADDR_WIDTH-1:0] tracePc [TRACE_DEPTH];
  logic [TRACE_DEPTH-1:0] traceValid;
  logic [TIDX_WIDTH:0]    count;
  logic                   writeAccepted;

  assign writeAccepted = regWriteEnable && (regWriteNum != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (writeAccepted) begin
      regs[regWriteNum] <= regWriteData;
    end
  end

  // Each read port forwards the in-flight write so decode needs no write-back path.
  for (genvar k = 0; k < READ_PORTS; k++) begin : readPort
    logic [NUM_WIDTH-1:0]  rdNum;
    logic [DATA_WIDTH-1:0] rdValue;
    logic                  bypassHit;

    assign rdNum     = regNum[k*NUM_WIDTH +: NUM_WIDTH];
    assign bypassHit = BYPASS_ON && writeAccepted && (regWriteNum == rdNum);

    always_comb begin
      rdValue = '0;
      if (reset && (rdNum != '0)) begin
        rdValue = bypassHit ? regWriteData : regs[rdNum];
      end
    end

    assign regReadData[k*DATA_WIDTH +: DATA_WIDTH] = rdValue;
  end

  always_comb begin
    regWatchData = '0;
    if (reset && (regWatchNum != '0)) begin
      regWatchData = regs[regWatchNum];
    end
  end

  // Trace buffer shifts toward the oldest slot; the count saturates rather than wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        tracePc[i] <= '0;
      end
      traceValid <= '0;
      count      <= '0;
    end else if (pcValid) begin
      tracePc[0] <= PC;
      for (int i = 1; i < TRACE_DEPTH; i++) begin
        tracePc[i] <= tracePc[i-1];
      end
      traceValid <= {traceValid[TRACE_DEPTH-2:0], 1'b1};
      if (count != TRACE_FULL) begin
        count <= count + 1'b1;
      end
    end
  end

  always_comb begin
    traceData = '0;
    if (reset && ({1'b0, traceIndex} < TRACE_FULL)) begin
      if (traceValid[traceIndex]) begin
        traceData = tracePc[traceIndex];
      end
    end
  end

  assign traceCount = reset ? count : '0;

endmodule
